// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered ALU with a start/done handshake, C/Z/N/V flags, a
//             multiply-high register and an iterative signed shift-add multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             jump,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic [WIDTH-1:0] hi
);

  localparam int c_msb = WIDTH - 1;
  localparam int c_cw  = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_width_v = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] c_wp1_v   = WIDTH'(WIDTH + 1);
  localparam logic [c_cw-1:0]  c_cnt_init = c_cw'(WIDTH);
  localparam logic [c_cw-1:0]  c_cnt_one  = c_cw'(1);

  localparam logic [5:0] c_op_jmp  = 6'b000000;
  localparam logic [5:0] c_op_jlt  = 6'b000100;
  localparam logic [5:0] c_op_jgt  = 6'b000101;
  localparam logic [5:0] c_op_jeq  = 6'b000110;
  localparam logic [5:0] c_op_jz   = 6'b000111;
  localparam logic [5:0] c_op_jge  = 6'b001000;
  localparam logic [5:0] c_op_jle  = 6'b001001;
  localparam logic [5:0] c_op_jne  = 6'b001010;
  localparam logic [5:0] c_op_jn   = 6'b001011;
  localparam logic [5:0] c_op_and  = 6'b001100;
  localparam logic [5:0] c_op_or   = 6'b001101;
  localparam logic [5:0] c_op_xor  = 6'b001110;
  localparam logic [5:0] c_op_not  = 6'b001111;
  localparam logic [5:0] c_op_nand = 6'b010000;
  localparam logic [5:0] c_op_nor  = 6'b010001;
  localparam logic [5:0] c_op_xnor = 6'b010010;
  localparam logic [5:0] c_op_mov  = 6'b010011;
  localparam logic [5:0] c_op_add  = 6'b010100;
  localparam logic [5:0] c_op_adc  = 6'b010101;
  localparam logic [5:0] c_op_ado  = 6'b010110;
  localparam logic [5:0] c_op_sub  = 6'b011000;
  localparam logic [5:0] c_op_sbc  = 6'b011001;
  localparam logic [5:0] c_op_sbo  = 6'b011010;
  localparam logic [5:0] c_op_mul  = 6'b011100;
  localparam logic [5:0] c_op_mla  = 6'b011101;
  localparam logic [5:0] c_op_mls  = 6'b011110;
  localparam logic [5:0] c_op_mrt  = 6'b011111;
  localparam logic [5:0] c_op_lsl  = 6'b100000;
  localparam logic [5:0] c_op_lsr  = 6'b100001;
  localparam logic [5:0] c_op_asr  = 6'b100010;
  localparam logic [5:0] c_op_ror  = 6'b100100;
  localparam logic [5:0] c_op_rrc  = 6'b100101;
  localparam logic [5:0] c_op_stp  = 6'b111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_result, r_hi;
  logic             r_done, r_jump, r_carry, r_zero, r_neg, r_ovf;

  logic [WIDTH-1:0] r_mcand, r_acc, r_mq, r_addend;
  logic [c_cw-1:0]  r_cnt;
  logic             r_sign;
  logic [1:0]       r_mop;

  logic w_accept, w_fix_wr, w_is_mul;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] w_add_rhs, w_sub_rhs;
  logic             w_add_cin, w_sub_bin, w_add_v, w_sub_v;
  logic [WIDTH:0]   w_add_sum, w_sub_dif;
  logic             w_lt, w_eq;
  logic [WIDTH-1:0] w_asr, w_ror, w_ror_amt, w_rrc_amt;
  logic [WIDTH:0]   w_rrc_vec, w_rrc;

  assign w_add_rhs = (opcode == c_op_ado) ? c_one : b;
  assign w_add_cin = (opcode == c_op_adc) & r_carry;
  assign w_add_sum = {1'b0, a} + {1'b0, w_add_rhs} + {{WIDTH{1'b0}}, w_add_cin};
  assign w_add_v   = (a[c_msb] == w_add_rhs[c_msb]) & (w_add_sum[c_msb] != a[c_msb]);

  // SBC borrows in when C is clear: a - b + C - 1 == a - b - ~C
  assign w_sub_rhs = (opcode == c_op_sbo) ? c_one : b;
  assign w_sub_bin = (opcode == c_op_sbc) & ~r_carry;
  assign w_sub_dif = {1'b0, a} - {1'b0, w_sub_rhs} - {{WIDTH{1'b0}}, w_sub_bin};
  assign w_sub_v   = (a[c_msb] != w_sub_rhs[c_msb]) & (w_sub_dif[c_msb] != a[c_msb]);

  assign w_lt = $signed(a) < $signed(b);
  assign w_eq = (a == b);

  assign w_asr     = $signed(a) >>> b;
  assign w_ror_amt = b % c_width_v;
  assign w_ror     = (a >> w_ror_amt) | (a << (c_width_v - w_ror_amt));
  assign w_rrc_amt = b % c_wp1_v;
  assign w_rrc_vec = {r_carry, a};
  assign w_rrc     = (w_rrc_vec >> w_rrc_amt) | (w_rrc_vec << (c_wp1_v - w_rrc_amt));

  assign w_is_mul = (opcode == c_op_mul) | (opcode == c_op_mla) | (opcode == c_op_mls);

  logic [WIDTH-1:0] w_res;
  logic             w_wr, w_cv, w_c, w_v, w_jmp;

  always_comb begin
    w_res = r_result;
    w_wr  = 1'b1;
    w_cv  = 1'b0;
    w_c   = r_carry;
    w_v   = r_ovf;
    w_jmp = 1'b0;
    case (opcode)
      c_op_jmp:  begin w_res = d; w_jmp = 1'b1;            end
      c_op_jlt:  begin w_res = d; w_jmp = w_lt;            end
      c_op_jgt:  begin w_res = d; w_jmp = ~w_lt & ~w_eq;   end
      c_op_jeq:  begin w_res = d; w_jmp = w_eq;            end
      c_op_jz:   begin w_res = d; w_jmp = (a == '0);       end
      c_op_jge:  begin w_res = d; w_jmp = ~w_lt;           end
      c_op_jle:  begin w_res = d; w_jmp = w_lt | w_eq;     end
      c_op_jne:  begin w_res = d; w_jmp = ~w_eq;           end
      c_op_jn:   begin w_res = d; w_jmp = a[c_msb];        end
      c_op_and:  w_res = a & b;
      c_op_or:   w_res = a | b;
      c_op_xor:  w_res = a ^ b;
      c_op_not:  w_res = ~a;
      c_op_nand: w_res = ~(a & b);
      c_op_nor:  w_res = ~(a | b);
      c_op_xnor: w_res = ~(a ^ b);
      c_op_mov:  w_res = a;
      c_op_add, c_op_adc, c_op_ado: begin
        w_res = w_add_sum[WIDTH-1:0];
        w_cv  = 1'b1;
        w_c   = w_add_sum[WIDTH];
        w_v   = w_add_v;
      end
      c_op_sub, c_op_sbc, c_op_sbo: begin
        w_res = w_sub_dif[WIDTH-1:0];
        w_cv  = 1'b1;
        w_c   = w_sub_dif[WIDTH];
        w_v   = w_sub_v;
      end
      c_op_mrt:  w_res = r_hi;
      c_op_lsl:  w_res = a << b;
      c_op_lsr:  w_res = a >> b;
      c_op_asr:  w_res = w_asr;
      c_op_ror:  w_res = w_ror;
      // a rotate through carry has no signed meaning, so V is cleared
      c_op_rrc: begin
        w_res = w_rrc[WIDTH-1:0];
        w_cv  = 1'b1;
        w_c   = w_rrc[WIDTH];
        w_v   = 1'b0;
      end
      c_op_stp:  w_res = '0;
      default:   w_wr = 1'b0;
    endcase
  end

  // ---------------- iterative multiplier ----------------
  logic [WIDTH-1:0]   w_mx, w_my, w_mx_mag, w_my_mag;
  logic [WIDTH:0]     w_step;
  logic [2*WIDTH-1:0] w_pmag, w_prod, w_addend, w_fix;

  assign w_mx     = (opcode == c_op_mul) ? a : d;
  assign w_my     = (opcode == c_op_mul) ? b : a;
  assign w_mx_mag = w_mx[c_msb] ? -w_mx : w_mx;
  assign w_my_mag = w_my[c_msb] ? -w_my : w_my;

  assign w_step   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);

  assign w_pmag   = {r_acc, r_mq};
  assign w_prod   = r_sign ? -w_pmag : w_pmag;
  assign w_addend = {{WIDTH{r_addend[c_msb]}}, r_addend};

  always_comb begin
    case (r_mop)
      2'b01:   w_fix = w_prod + w_addend;
      2'b10:   w_fix = w_addend - w_prod;
      default: w_fix = w_prod;
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fix_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_is_mul) w_state_nxt = S_MULT;
        end
      end
      S_MULT:  if (r_cnt == c_cnt_one) w_state_nxt = S_FIX;
      S_FIX: begin
        w_fix_wr    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_hi     <= '0;
      r_done   <= 1'b0;
      r_jump   <= 1'b0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_addend <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_mop    <= 2'b00;
    end else begin
      r_done <= 1'b0;
      if (w_accept && !w_is_mul) begin
        r_done <= 1'b1;
        if (w_wr) begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_neg    <= w_res[c_msb];
          r_jump   <= w_jmp;
        end
        if (w_cv) begin
          r_carry <= w_c;
          r_ovf   <= w_v;
        end
      end
      if (w_accept && w_is_mul) begin
        r_mcand  <= w_mx_mag;
        r_mq     <= w_my_mag;
        r_acc    <= '0;
        r_cnt    <= c_cnt_init;
        r_sign   <= w_mx[c_msb] ^ w_my[c_msb];
        r_addend <= b;
        r_mop    <= opcode[1:0];
      end
      // one multiplier bit per cycle: add, then shift {acc,mq} right
      if (r_state == S_MULT) begin
        r_acc <= w_step[WIDTH:1];
        r_mq  <= {w_step[0], r_mq[WIDTH-1:1]};
        r_cnt <= r_cnt - c_cnt_one;
      end
      if (w_fix_wr) begin
        r_result <= w_fix[WIDTH-1:0];
        r_hi     <= w_fix[2*WIDTH-1:WIDTH];
        r_zero   <= (w_fix[WIDTH-1:0] == '0);
        r_neg    <= w_fix[c_msb];
        r_jump   <= 1'b0;
        r_done   <= 1'b1;
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign jump   = r_jump;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign neg    = r_neg;
  assign ovf    = r_ovf;
  assign hi     = r_hi;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq: directed cases plus random ops
//             against an integer-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [5:0]        opcode;
  logic [WIDTH-1:0]  a, b, d;
  logic              busy, done, jump, carry, zero, neg, ovf;
  logic [WIDTH-1:0]  result, hi;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_result, m_hi;
  logic        m_c, m_z, m_n, m_v, m_jump;

  int ops_tab [34] = '{0, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19,
                       20, 21, 22, 24, 25, 26, 28, 29, 30, 31, 32, 33, 34, 36, 37, 62, 63};

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .a(a), .b(b), .d(d),
    .busy(busy), .done(done), .result(result), .jump(jump),
    .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .hi(hi)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_range(input int x);
    return (x > 32767) || (x < -32768);
  endfunction

  task automatic model_reset();
    m_result = '0; m_hi = '0;
    m_c = 0; m_z = 0; m_n = 0; m_v = 0; m_jump = 0;
  endtask

  task automatic model_exec(input logic [5:0] op, input logic [15:0] ia, ib, id);
    int ua, ub, sa, sb, sd, s, k, res;
    longint p, v;
    bit wr, cv, c, ov, j, mul;
    ua = int'(ia); ub = int'(ib);
    sa = int'($signed(ia)); sb = int'($signed(ib)); sd = int'($signed(id));
    wr = 1; cv = 0; c = m_c; ov = m_v; j = 0; mul = 0; res = 0; p = 0; s = 0;
    case (op)
      0:  begin res = int'(id); j = 1;          end
      4:  begin res = int'(id); j = (sa <  sb); end
      5:  begin res = int'(id); j = (sa >  sb); end
      6:  begin res = int'(id); j = (sa == sb); end
      7:  begin res = int'(id); j = (sa == 0);  end
      8:  begin res = int'(id); j = (sa >= sb); end
      9:  begin res = int'(id); j = (sa <= sb); end
      10: begin res = int'(id); j = (sa != sb); end
      11: begin res = int'(id); j = (sa <  0);  end
      12: res = ua & ub;
      13: res = ua | ub;
      14: res = ua ^ ub;
      15: res = ~ua;
      16: res = ~(ua & ub);
      17: res = ~(ua | ub);
      18: res = ~(ua ^ ub);
      19: res = ua;
      20: begin s = ua + ub;              cv = 1; c = s[16]; ov = out_of_range(sa + sb); res = s; end
      21: begin s = ua + ub + int'(m_c);  cv = 1; c = s[16]; ov = out_of_range(sa + sb + int'(m_c)); res = s; end
      22: begin s = ua + 1;               cv = 1; c = s[16]; ov = out_of_range(sa + 1); res = s; end
      24: begin s = ua - ub;              cv = 1; c = (s < 0); ov = out_of_range(sa - sb); res = s; end
      25: begin s = ua - ub + int'(m_c) - 1; cv = 1; c = (s < 0); ov = out_of_range(sa - sb + int'(m_c) - 1); res = s; end
      26: begin s = ua - 1;               cv = 1; c = (s < 0); ov = out_of_range(sa - 1); res = s; end
      28: begin mul = 1; p = longint'(sa) * longint'(sb); end
      29: begin mul = 1; p = longint'(sd) * longint'(sa) + longint'(sb); end
      30: begin mul = 1; p = longint'(sb) - longint'(sd) * longint'(sa); end
      31: res = int'(m_hi);
      32: res = (ub >= 16) ? 0 : (ua << ub);
      33: res = (ub >= 16) ? 0 : (ua >> ub);
      34: res = (ub >= 16) ? ((sa < 0) ? 'hFFFF : 0) : (sa >>> ub);
      36: begin k = ub % 16; res = (ua >> k) | (ua << (16 - k)); end
      37: begin
        k = ub % 17;
        v = longint'(m_c) * 65536 + longint'(ua);
        v = ((v >> k) | (v << (17 - k))) & 'h1FFFF;
        cv = 1; c = v[16]; ov = 0; res = int'(v & 'hFFFF);
      end
      63: res = 0;
      default: wr = 0;
    endcase
    if (mul) begin
      res  = int'(p & 'hFFFF);
      m_hi = p[31:16];
    end
    if (wr) begin
      m_result = res[15:0];
      m_z      = (res[15:0] == 16'h0000);
      m_n      = res[15];
      m_jump   = j;
      if (cv) begin
        m_c = c;
        m_v = ov;
      end
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFF;
      5:       return 16'($urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is visible, so the
  // next call starts in the same cycle as done.
  task automatic run_op(input logic [5:0] op, input logic [15:0] ia, ib, id, input bit poke);
    int lat;
    bit busy_ok, is_mul;
    is_mul = (op == 6'd28) || (op == 6'd29) || (op == 6'd30);
    start = 1'b1; opcode = op; a = ia; b = ib; d = id;
    @(negedge clk);
    start = 1'b0; opcode = 6'($urandom); a = 16'($urandom); b = 16'($urandom); d = 16'($urandom);
    lat = 0; busy_ok = 1;
    while (!done && lat < 40) begin
      if (is_mul && lat < 16 && !busy) busy_ok = 0;
      start = (poke && lat == 4);
      if (poke && lat == 4) opcode = 6'd20;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    model_exec(op, ia, ib, id);
    check_val($sformatf("latency op%0d", op), lat, is_mul ? 17 : 0);
    if (is_mul) check_val($sformatf("busy op%0d", op), {31'd0, busy_ok}, 1);
    check_val($sformatf("busy_at_done op%0d", op), {31'd0, busy}, 0);
    check_val($sformatf("result op%0d", op), {16'd0, result}, {16'd0, m_result});
    check_val($sformatf("hi op%0d", op), {16'd0, hi}, {16'd0, m_hi});
    check_val($sformatf("flags{j,c,z,n,v} op%0d", op), {27'd0, jump, carry, zero, neg, ovf},
              {27'd0, m_jump, m_c, m_z, m_n, m_v});
  endtask

  initial begin
    logic [5:0] op;
    bit done_seen;
    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0; d = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_val("reset result", {16'd0, result}, 0);
    check_val("reset hi", {16'd0, hi}, 0);
    check_val("reset flags", {25'd0, busy, done, jump, carry, zero, neg, ovf}, 0);

    run_op(6'd20, 16'h7FFF, 16'h0001, 16'h0000, 0);
    check_val("add_ovf result", {16'd0, result}, 32'h8000);
    check_val("add_ovf {c,z,n,v}", {28'd0, carry, zero, neg, ovf}, 32'b0011);

    run_op(6'd20, 16'hFFFF, 16'h0001, 16'h0000, 0);
    check_val("add_wrap {c,z}", {30'd0, carry, zero}, 32'b11);
    run_op(6'd21, 16'h0002, 16'h0003, 16'h0000, 0);
    check_val("adc result", {16'd0, result}, 6);
    check_val("adc carry", {31'd0, carry}, 0);

    run_op(6'd28, 16'hFFFD, 16'd1234, 16'h0000, 1);
    check_val("mul_neg result", {16'd0, result}, 32'hF18A);
    check_val("mul_neg hi", {16'd0, hi}, 32'hFFFF);
    @(negedge clk);
    check_val("done single pulse", {31'd0, done}, 0);

    run_op(6'd28, 16'h7FFF, 16'h7FFF, 16'h0000, 0);
    check_val("mul_max {hi,result}", {hi, result}, 32'h3FFF0001);
    run_op(6'd31, 16'h1111, 16'h2222, 16'h3333, 0);
    check_val("mrt result", {16'd0, result}, 32'h3FFF);

    run_op(6'd4, 16'hFFFF, 16'h0001, 16'h0040, 0);
    check_val("jlt jump", {31'd0, jump}, 1);
    check_val("jlt result", {16'd0, result}, 32'h0040);
    run_op(6'd11, 16'h0005, 16'h0000, 16'h0040, 0);
    check_val("jn jump", {31'd0, jump}, 0);
    run_op(6'd0, 16'h0000, 16'h0000, 16'h0010, 0);
    run_op(6'd12, 16'h00FF, 16'h0F0F, 16'h0000, 0);
    check_val("and clears jump", {31'd0, jump}, 0);

    run_op(6'd20, 16'hFFFF, 16'h0001, 16'h0000, 0);
    run_op(6'd37, 16'h0001, 16'h0001, 16'h0000, 0);
    check_val("rrc result", {16'd0, result}, 32'h8000);
    check_val("rrc carry", {31'd0, carry}, 1);
    run_op(6'd34, 16'h8000, 16'd20, 16'h0000, 0);
    check_val("asr big", {16'd0, result}, 32'hFFFF);
    run_op(6'd32, 16'hFFFF, 16'd16, 16'h0000, 0);
    check_val("lsl 16", {16'd0, result}, 0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      else                           op = 6'(ops_tab[$urandom_range(0, 33)]);
      run_op(op, rnd16(), rnd16(), rnd16(), 0);
    end

    // leave every flag and register nonzero, then reset during a multiply
    run_op(6'd28, 16'h7FFF, 16'h7FFF, 16'h0000, 0);
    run_op(6'd20, 16'h8000, 16'h8000, 16'h0000, 0);
    run_op(6'd0, 16'h0000, 16'h0000, 16'h8000, 0);
    start = 1'b1; opcode = 6'd28; a = 16'h1234; b = 16'h0567; d = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_val("rst_mid busy", {31'd0, busy}, 0);
    check_val("rst_mid result", {16'd0, result}, 0);
    check_val("rst_mid hi", {16'd0, hi}, 0);
    check_val("rst_mid flags", {27'd0, jump, carry, zero, neg, ovf}, 0);
    done_seen = 0;
    repeat (25) begin
      if (done) done_seen = 1;
      @(negedge clk);
    end
    check_val("rst_mid no done", {31'd0, done_seen}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the combinational datapath ALU.
- Runs one operation per start/done handshake.
- Holds carry, zero, negative and overflow flags in registers, plus a multiply-high register.
- Replaces the external multiplier with an internal iterative signed shift-add unit.
- Sits between the decoder/state machine and the register file; opcode encodings are unchanged from the current ALU.

Parameters:
- WIDTH, 16, data width of operands, result and hi register (≥4).

Ports:
- clk, input, 1, system clock. Everything registers on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request to begin an operation. Sampled only when busy=0.
- opcode, input, 6, operation select. Encodings as listed in Behaviour.
- a, input, WIDTH, source operand 1 (Rs1), signed.
- b, input, WIDTH, source operand 2 (Rs2), signed. Also the shift/rotate amount.
- d, input, WIDTH, destination operand (Rd), signed. Also the jump target.
- busy, output, 1, high while a multi-cycle op is in progress.
- done, output, 1, one-cycle pulse when result/jump/flags are updated.
- result, output, WIDTH, registered result. Held until the next completion.
- jump, output, 1, registered jump decision. Held until the next completion.
- carry, output, 1, carry/borrow flag C.
- zero, output, 1, flag Z.
- neg, output, 1, flag N.
- ovf, output, 1, signed overflow flag V.
- hi, output, WIDTH, upper half of the last multiply.

Behaviour:
- Reset (rst=1 at an edge): state IDLE. busy, done, jump, carry, zero, neg and ovf all 0; result=0; hi=0.
- Reset mid-multiply aborts the operation; no done pulse follows. rst has priority over start.
- Operands and opcode are latched on the edge where start=1 and busy=0. start while busy=1 is ignored.
- States:
  - IDLE: start with a single-cycle op → result registered at the same edge; done=1 for the next cycle; stay IDLE. start with MUL/MLA/MLS → MULT, busy=1.
  - MULT: WIDTH cycles. Shift-add on operand magnitudes (two's-complement negate when negative), one multiplier bit per cycle.
  - FIX: 1 cycle. Applies the sign (sign = xor of operand signs), adds/subtracts b for MLA/MLS, writes result/hi. done=1, busy=0, → IDLE.
- Multiply latency: done is high in the cycle WIDTH+1 edges after the start edge (17 for WIDTH=16).
- Back-to-back: start may be asserted in the same cycle as done.
- Z and N are updated from result on every op that writes result.
- C and V are updated only by ADD, ADC, ADO, SUB, SBC, SBO and RRC. All other ops leave C and V unchanged.
- NOP (111110) and undefined opcodes: done pulses; result, flags, hi and jump are unchanged.
- jump is cleared to 0 on every non-jump completion.
- Opcodes (a, b, d signed WIDTH bits):
  - 000000 JMP: jump=1.
  - 000100..000111: a<b, a>b, a==b, a==0.
  - 001000..001011: a>=b, a<=b, a!=b, a<0.
  - All jump ops: result=d; jump = condition (signed compare).
  - 001100..010011: AND, OR, XOR, NOT a, NAND, NOR, XNOR, MOV a.
  - 010100 ADD: {C,result} = {0,a}+{0,b}; V = signed overflow.
  - 010101 ADC: {C,result} = {0,a}+{0,b}+C.
  - 010110 ADO: a+1.
  - 011000 SUB: {C,result} = {0,a}-{0,b}; C = borrow bit.
  - 011001 SBC: a-b+C-1.
  - 011010 SBO: a-1.
  - 011100 MUL: {hi,result} = a*b, signed 2·WIDTH.
  - 011101 MLA: {hi,result} = d*a + sext(b).
  - 011110 MLS: {hi,result} = sext(b) - d*a.
  - 011111 MRT: result = hi.
  - 100000 LSL and 100001 LSR: shift amount = unsigned b; b ≥ WIDTH gives 0.
  - 100010 ASR: b ≥ WIDTH gives all copies of a's sign bit.
  - 100100 ROR: rotate a right by b mod WIDTH.
  - 100101 RRC: rotate the (WIDTH+1)-bit vector {C,a} right by b mod (WIDTH+1); result = low WIDTH bits, C = top bit.
  - 111111 STP: result=0.

Test Plan:
- ADD a=0x7FFF b=0x0001 → done one cycle after start; result=0x8000; C=0, V=1, N=1, Z=0.
- ADD 0xFFFF+0x0001 (result=0, C=1, Z=1), then ADC a=2 b=3 → result=6, C=0.
- MUL a=0xFFFD (-3) b=1234 → busy=1 for 16 cycles; done exactly 17 cycles after start; result=0xF18A, hi=0xFFFF. A start pulse at cycle 5 is ignored.
- MUL 0x7FFF*0x7FFF → hi=0x3FFF, result=0x0001. Then MRT → result=0x3FFF; C and V unchanged.
- JC1 a=0xFFFF b=0x0001 d=0x0040 → jump=1, result=0x0040. JC8 a=5 → jump=0. A following AND → jump=0.
- Shifts, rotates and reset:
  - C=1, RRC a=0x0001 b=1 → result=0x8000, C=1.
  - ASR a=0x8000 b=20 → 0xFFFF.
  - LSL b=16 → 0.
  - rst at MULT cycle 5 → next cycle busy=0, result=0, flags 0, and no done pulse afterwards.
